// File: rtl/image_rom_arbiter.sv
// rtl/image_rom_arbiter.sv - two-port round-robin arbiter in front of a shared image ROM
//
// Ports:
//   clk, rst_n            single clock, asynchronous active-low reset
//   req0/addr0/gnt0       port 0 request, address ({y, x}) and combinational grant
//   rgb0/vld0             port 0 returned pixel (held) and one-cycle return strobe
//   req1/addr1/gnt1       port 1 request, address and grant
//   rgb1/vld1             port 1 returned pixel and return strobe
//   rom_address           registered address to the shared ROM
//   rom_rgb               ROM data, valid ROM_LATENCY clocks after rom_address changes
//
// ROM_LATENCY must lie in 1..4.
module image_rom_arbiter #(
    parameter int ADDR_W      = 14,
    parameter int RGB_W       = 12,
    parameter int ROM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic [RGB_W-1:0]  rgb0,
    output logic              vld0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic [RGB_W-1:0]  rgb1,
    output logic              vld1,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [RGB_W-1:0]  rom_rgb
);

    // Stage 0 is loaded at the end of the transfer cycle; the last stage lines
    // up with the cycle in which rom_rgb holds the data for that transfer.
    localparam int DEPTH = ROM_LATENCY + 1;

    // 1 when port 1 won the most recent transfer; reset to 1 so port 0 wins
    // the first contention.
    logic             last_gnt;
    logic [DEPTH-1:0] tag_vld;
    logic [DEPTH-1:0] tag_id;
    logic             xfer;

    // Grants are gated by rst_n so they read low while reset is held, even
    // though they are otherwise purely combinational.
    always_comb begin
        gnt0 = rst_n & req0 & (~req1 | last_gnt);
        gnt1 = rst_n & req1 & (~req0 | ~last_gnt);
        xfer = gnt0 | gnt1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt    <= 1'b1;
            rom_address <= '0;
            tag_vld     <= '0;
            tag_id      <= '0;
            vld0        <= 1'b0;
            vld1        <= 1'b0;
            rgb0        <= '0;
            rgb1        <= '0;
        end else begin
            if (xfer) begin
                last_gnt    <= gnt1;
                rom_address <= gnt1 ? addr1 : addr0;
            end
            tag_vld <= {tag_vld[DEPTH-2:0], xfer};
            tag_id  <= {tag_id[DEPTH-2:0], gnt1};
            vld0    <= tag_vld[DEPTH-1] & ~tag_id[DEPTH-1];
            vld1    <= tag_vld[DEPTH-1] & tag_id[DEPTH-1];
            if (tag_vld[DEPTH-1] && !tag_id[DEPTH-1]) begin
                rgb0 <= rom_rgb;
            end
            if (tag_vld[DEPTH-1] && tag_id[DEPTH-1]) begin
                rgb1 <= rom_rgb;
            end
        end
    end

endmodule

// File: doc/image_rom_arbiter.md
IMAGE_ROM_ARBITER -- requirements
Module: image_rom_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 14, width of all ROM address ports ({y[6:0], x[6:0]}).
REQ-002 Parameter: RGB_W, default 12, width of all pixel data ports (4-bit R,G,B).
REQ-003 Parameter: ROM_LATENCY, default 1, ROM read latency in clocks from rom_address change to valid rom_rgb; legal range 1..4.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: req0  input  1  port 0 read request.
REQ-007 Port: addr0  input  ADDR_W  port 0 read address, stable while req0 high.
REQ-008 Port: gnt0  output  1  port 0 grant; transfer when req0 & gnt0.
REQ-009 Port: rgb0  output  RGB_W  port 0 returned pixel, held until next port 0 return.
REQ-010 Port: vld0  output  1  one-cycle pulse, rgb0 updated this cycle.
REQ-011 Port: req1, addr1, gnt1, rgb1, vld1  same directions/widths/meaning as port 0, for port 1.
REQ-012 Port: rom_address  output  ADDR_W  registered address driven to the shared image ROM.
REQ-013 Port: rom_rgb  input  RGB_W  data returned by the shared image ROM.

Function
REQ-014 The block SHALL share one image ROM between two requesters, at most one transfer per cycle.
REQ-015 gnt0/gnt1 SHALL be combinational from req0, req1 and the priority pointer; at most one high per cycle; never high without its req.
REQ-016 Single requester SHALL be granted in the same cycle it asserts req.
REQ-017 Both requesting: grant the port other than the last-granted port (round-robin); pointer updates only on a transfer.
REQ-018 On a transfer in cycle N, rom_address SHALL take the winner's address at the end of cycle N; rom_address holds its value when no transfer occurs.
REQ-019 A tag pipeline (valid bit + port id) of depth ROM_LATENCY+1 SHALL track each transfer; no other state machine or counter may delay it.
REQ-020 For a transfer in cycle N, rgbX SHALL be registered from rom_rgb at the end of cycle N+1+ROM_LATENCY and vldX high exactly in cycle N+2+ROM_LATENCY (N+3 at default).
REQ-021 Back-to-back transfers SHALL return in issue order, one per cycle, no gaps or drops, with full throughput (one transfer every cycle sustained).
REQ-022 vld0 and vld1 SHALL never be high in the same cycle.
REQ-023 A requester holding req continuously while the other also requests SHALL be granted within 2 cycles (no starvation).
REQ-024 Address changes while req high and no grant SHALL be tolerated; the address sampled in the grant cycle is used.

Reset
REQ-025 While rst_n low: gnt0=gnt1=0, vld0=vld1=0, rgb0=rgb1=0, rom_address=0, tag pipeline cleared, pointer set so port 0 wins first contention.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight transfers; no vld pulse for any pre-reset transfer after rst_n rises.
REQ-027 Reset assertion SHALL take effect without a clock edge; first transfer possible in the first cycle with rst_n high.

Verification
REQ-028 Single read: req0=1, addr0=14'h0081 for one cycle N, ROM preloaded rom[0x0081]=12'hF0A -> gnt0=1 in N, rom_address=0x0081 in N+1, vld0=1 and rgb0=12'hF0A in N+3, vld1 never high.
REQ-029 Contention from reset: req0=req1=1 held, addr0=0x0010, addr1=0x0020 -> grants alternate 0,1,0,1; vld0/vld1 alternate starting at cycle 3 with rom[0x10], rom[0x20].
REQ-030 Streaming: req1=1 for 16 cycles, addr1 = 0..15 incrementing on each grant -> 16 consecutive vld1 pulses, rgb1 = rom[0..15] in order.
REQ-031 Reset mid-flight: transfer on port 0 in cycle N, rst_n=0 in N+1 for one cycle -> no vld0 ever, rgb0=0, rom_address=0.
REQ-032 ROM_LATENCY=3 build: single port 1 read at cycle N -> vld1 exactly in N+5 with correct data.
REQ-033 Random req/addr on both ports for 10000 cycles vs. scoreboard -> every transfer returns once, in order, correct data, no starvation beyond 2 cycles.
